// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache/memory message types plus the arbiter's ID width and state encoding.
// The arbiter top and its ID queue both import this package.
package cache_mem_arbiter_pkg;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam int ARB_ID_W = 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arb_id_queue.sv
// FIFO of requester IDs for memory requests still awaiting a response.
// A push is refused while full, even if a pop happens in the same cycle.
module cache_mem_arb_id_queue
  import cache_mem_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [ARB_ID_W-1:0] i_push_id,
  input  logic                i_pop,
  output logic [ARB_ID_W-1:0] o_head_id,
  output logic                o_full,
  output logic                o_empty
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ARB_ID_W-1:0] r_mem [MAX_OUT];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_push_ok;
  logic                w_pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(MAX_OUT));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head_id = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: ID storage is not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_id;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin burst arbiter sharing one memory port between the I-cache (port 0)
// and D-cache (port 1); in-order responses are routed back via an outstanding-ID queue.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BEATS   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         i_req0_val,
  output logic         o_req0_rdy,
  input  mem_req_4B_t  i_req0_msg,
  output logic         o_resp0_val,
  input  logic         i_resp0_rdy,
  output mem_resp_4B_t o_resp0_msg,

  input  logic         i_req1_val,
  output logic         o_req1_rdy,
  input  mem_req_4B_t  i_req1_msg,
  output logic         o_resp1_val,
  input  logic         i_resp1_rdy,
  output mem_resp_4B_t o_resp1_msg,

  output logic         o_memreq_val,
  input  logic         i_memreq_rdy,
  output mem_req_4B_t  o_memreq_msg,
  input  logic         i_memresp_val,
  output logic         o_memresp_rdy,
  input  mem_resp_4B_t i_memresp_msg
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic                r_owner;
  logic                w_owner_next;
  logic                r_prio;
  logic                w_prio_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [CNT_W:0]      w_count_inc;
  logic                w_last_beat;

  logic                w_grant;
  logic                w_grant_val;
  logic                w_port_rdy;
  logic                w_fire;
  logic                w_pop;
  logic                w_q_full;
  logic                w_q_empty;
  logic [ARB_ID_W-1:0] w_q_head;

  // One bit wider than r_count so the final beat compares against BEATS without wrapping.
  assign w_count_inc = {1'b0, r_count} + (CNT_W + 1)'(1);
  assign w_last_beat = (w_count_inc == (CNT_W + 1)'(BEATS));

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_prio_next  = r_prio;
    w_count_next = r_count;
    w_grant      = r_owner;
    w_grant_val  = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        w_grant     = (i_req0_val & i_req1_val) ? r_prio : i_req1_val;
        w_grant_val = i_req0_val | i_req1_val;
      end
      ARB_BURST: w_grant_val = r_owner ? i_req1_val : i_req0_val;
      default: ;
    endcase

    w_fire = w_grant_val & i_memreq_rdy & ~w_q_full;

    if (w_fire) begin
      if (r_state == ARB_IDLE) begin
        w_owner_next = w_grant;
        w_prio_next  = ~w_grant;
        if (BEATS > 1) begin
          w_count_next = CNT_W'(1);
          w_state_next = ARB_BURST;
        end
      end else if (w_last_beat) begin
        w_state_next = ARB_IDLE;
        w_count_next = '0;
      end else begin
        w_count_next = w_count_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_prio  <= w_prio_next;
      r_count <= w_count_next;
    end
  end

  // Request path: memreq_rdy only reaches the rdy outputs, never memreq_val.
  assign w_port_rdy   = i_memreq_rdy & ~w_q_full;
  assign o_memreq_val = w_grant_val & ~w_q_full;
  assign o_memreq_msg = w_grant ? i_req1_msg : i_req0_msg;
  assign o_req0_rdy   = w_port_rdy & ~w_grant;
  assign o_req1_rdy   = w_port_rdy & w_grant;

  assign o_resp0_val   = i_memresp_val & ~w_q_empty & (w_q_head == 1'b0);
  assign o_resp1_val   = i_memresp_val & ~w_q_empty & (w_q_head == 1'b1);
  assign o_resp0_msg   = i_memresp_msg;
  assign o_resp1_msg   = i_memresp_msg;
  assign o_memresp_rdy = ~w_q_empty & (w_q_head[0] ? i_resp1_rdy : i_resp0_rdy);
  assign w_pop         = i_memresp_val & o_memresp_rdy;

  cache_mem_arb_id_queue #(
    .MAX_OUT (MAX_OUT)
  ) u_id_queue (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_fire),
    .i_push_id (w_grant),
    .i_pop     (w_pop),
    .o_head_id (w_q_head),
    .o_full    (w_q_full),
    .o_empty   (w_q_empty)
  );

endmodule
